// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: fractional tick generator, filtered input, frame FSM, valid/ready holding register.
// Optional idle/end-of-packet detection is enabled by defining UART_RX_IDLE_DETECT_EN.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned OVERSAMPLING = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun
`ifdef UART_RX_IDLE_DETECT_EN
  ,
  output logic                 rx_idle,
  output logic                 rx_eop
`endif
);

  localparam longint unsigned INC   = longint'(BAUD) * longint'(OVERSAMPLING);
  localparam int unsigned     ACC_W = $clog2(longint'(CLK_FREQ) + INC) + 1;
  localparam int unsigned     CNT_W = $clog2(OVERSAMPLING);
  localparam int unsigned     IDX_W = 4;

  localparam logic [ACC_W-1:0] ACC_INC       = ACC_W'(INC);
  localparam logic [ACC_W-1:0] ACC_MOD       = ACC_W'(CLK_FREQ);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(OVERSAMPLING - 1);
  localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

  generate
    if (OVERSAMPLING < 8 || (OVERSAMPLING & (OVERSAMPLING - 1)) != 0) begin : g_bad_os
      $error("uart_rx_param: OVERSAMPLING must be a power of 2 and at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_rx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
      $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (INC > longint'(CLK_FREQ)) begin : g_bad_rate
      $error("uart_rx_param: BAUD*OVERSAMPLING must not exceed CLK_FREQ");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  logic [ACC_W-1:0]     acc_q, acc_d, acc_sum_c;
  logic                 tick_c;
  logic [1:0]           sync_q;
  logic [1:0]           filt_cnt_q, filt_cnt_d;
  logic                 filt_q, filt_d;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 ferr_c, perr_c, done_c;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 frm_q, frm_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;

  // Fractional accumulator: average tick period is CLK_FREQ/(BAUD*OVERSAMPLING) clocks.
  always_comb begin
    acc_sum_c = acc_q + ACC_INC;
    tick_c    = (acc_sum_c >= ACC_MOD);
    acc_d     = tick_c ? (acc_sum_c - ACC_MOD) : acc_sum_c;
  end

  // Saturating 2-bit filter with hysteresis, advanced only on ticks.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    filt_d     = filt_q;
    if (tick_c) begin
      if (sync_q[1] && filt_cnt_q != 2'b11) begin
        filt_cnt_d = filt_cnt_q + 2'b01;
      end else if (!sync_q[1] && filt_cnt_q != 2'b00) begin
        filt_cnt_d = filt_cnt_q - 2'b01;
      end
    end
    if (filt_cnt_d == 2'b00) begin
      filt_d = 1'b0;
    end else if (filt_cnt_d == 2'b11) begin
      filt_d = 1'b1;
    end
  end

  always_comb begin
    ferr_c = ferr_q | ~filt_q;
    if (PARITY == 1) begin
      perr_c = ~(^shift_q ^ par_q);
    end else if (PARITY == 2) begin
      perr_c = ^shift_q ^ par_q;
    end else begin
      perr_c = 1'b0;
    end
  end

  // Frame FSM: next state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_c && !filt_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (tick_c) begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            if (filt_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              idx_d   = '0;
              ferr_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shift_d = {filt_q, shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST_DATA) begin
              idx_d   = '0;
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            par_d   = filt_q;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            ferr_d = ferr_c;
            if (idx_q == IDX_LAST_STOP) begin
              done_c  = 1'b1;
              state_d = ferr_c ? S_WAIT_IDLE : S_IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WAIT_IDLE: begin
        // Hold off restarting while the line stays low (break).
        if (filt_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register with overrun detection.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    frm_d   = frm_q;
    ovr_d   = ovr_q;
    brk_d   = 1'b0;
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done_c) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        perr_d  = perr_c;
        frm_d   = ferr_c;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
      brk_d = (shift_q == '0) && (PARITY == 0 || !par_q) && ferr_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      sync_q     <= 2'b11;
      filt_cnt_q <= 2'b11;
      filt_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      frm_q      <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      sync_q     <= {sync_q[0], rxd};
      filt_cnt_q <= filt_cnt_d;
      filt_q     <= filt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      frm_q      <= frm_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = frm_q;
  assign rx_break      = brk_q;
  assign rx_overrun    = ovr_q;

`ifdef UART_RX_IDLE_DETECT_EN
  localparam int unsigned GAP_MAX = 2 * OVERSAMPLING;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             idle_q, idle_d;
  logic             eop_q, eop_d;
  logic             seen_q, seen_d;

  // Line-gap counter; end-of-packet marks the first idle edge after traffic.
  always_comb begin
    gap_d = gap_q;
    if (state_q != S_IDLE) begin
      gap_d = '0;
    end else if (tick_c && gap_q != GAP_W'(GAP_MAX)) begin
      gap_d = gap_q + GAP_W'(1);
    end
    idle_d = (gap_d == GAP_W'(GAP_MAX));
    eop_d  = idle_d && !idle_q && seen_q;
    seen_d = seen_q;
    if (done_c) begin
      seen_d = 1'b1;
    end else if (eop_d) begin
      seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q  <= GAP_W'(GAP_MAX);
      idle_q <= 1'b1;
      eop_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      gap_q  <= gap_d;
      idle_q <= idle_d;
      eop_q  <= eop_d;
      seen_q <= seen_d;
    end
  end

  assign rx_idle = idle_q;
  assign rx_eop  = eop_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 and a 7E2 receiver driven with directed and random frames,
// checked against a queue-based frame model.
module tb_uart_rx_param;

  localparam int unsigned BIT_CLKS = 16;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic rxd8   = 1'b1;
  logic rxd7   = 1'b1;
  logic rdy8   = 1'b0;
  logic rdy7   = 1'b0;

  logic [7:0] rx_data8;
  logic       rx_valid8, rx_perr8, rx_ferr8, rx_brk8, rx_ovr8;
  logic [6:0] rx_data7;
  logic       rx_valid7, rx_perr7, rx_ferr7, rx_brk7, rx_ovr7;

  typedef struct packed {
    logic [8:0] d;
    logic       p;
    logic       f;
  } exp_t;

  exp_t exp8[$];
  exp_t exp7[$];

  int errors    = 0;
  int checks    = 0;
  int brk8_exp  = 0;
  int brk8_seen = 0;
  int brk7_exp  = 0;
  int brk7_seen = 0;
  int cnt8      = 0;
  int cnt7      = 0;

  logic [7:0] last8      = '0;
  logic       last_ferr8 = 1'b0;
  logic [6:0] last7      = '0;
  logic       last_perr7 = 1'b0;

  bit   rmode8  = 1'b0;
  bit   rmode7  = 1'b0;
  logic rforce8 = 1'b1;
  logic rforce7 = 1'b1;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLING(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut8 (
    .clk(clk), .rst(rst), .rxd(rxd8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ready(rdy8),
    .rx_parity_err(rx_perr8), .rx_frame_err(rx_ferr8),
    .rx_break(rx_brk8), .rx_overrun(rx_ovr8)
  );

  uart_rx_param #(
    .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLING(16),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) dut7 (
    .clk(clk), .rst(rst), .rxd(rxd7),
    .rx_data(rx_data7), .rx_valid(rx_valid7), .rx_ready(rdy7),
    .rx_parity_err(rx_perr7), .rx_frame_err(rx_ferr7),
    .rx_break(rx_brk7), .rx_overrun(rx_ovr7)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready: either forced by the scenario or random.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      rdy8 = rmode8 ? 1'($urandom_range(0, 1)) : rforce8;
      rdy7 = rmode7 ? 1'($urandom_range(0, 1)) : rforce7;
    end
  end

  // Held word must match the oldest expected frame whenever it is visible.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_brk8) brk8_seen++;
      if (rx_valid8) begin
        if (exp8.size() == 0) begin
          chk("dut8_unexpected_valid", 32'(rx_valid8), 32'd0);
        end else begin
          chk("dut8_data", 32'(rx_data8), 32'(exp8[0].d));
          chk("dut8_parity_err", 32'(rx_perr8), 32'(exp8[0].p));
          chk("dut8_frame_err", 32'(rx_ferr8), 32'(exp8[0].f));
          if (rdy8) begin
            last8      = rx_data8;
            last_ferr8 = rx_ferr8;
            cnt8++;
            exp8.delete(0);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_brk7) brk7_seen++;
      if (rx_valid7) begin
        if (exp7.size() == 0) begin
          chk("dut7_unexpected_valid", 32'(rx_valid7), 32'd0);
        end else begin
          chk("dut7_data", 32'(rx_data7), 32'(exp7[0].d));
          chk("dut7_parity_err", 32'(rx_perr7), 32'(exp7[0].p));
          chk("dut7_frame_err", 32'(rx_ferr7), 32'(exp7[0].f));
          if (rdy7) begin
            last7      = rx_data7;
            last_perr7 = rx_perr7;
            cnt7++;
            exp7.delete(0);
          end
        end
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic line8(input logic v, input int unsigned clks);
    rxd8 = v;
    repeat (clks) @(posedge clk);
    #2;
  endtask

  task automatic line7(input logic v, input int unsigned clks);
    rxd7 = v;
    repeat (clks) @(posedge clk);
    #2;
  endtask

  task automatic send8(input logic [7:0] d, input logic stop_low, input int unsigned gap, input bit push);
    if (push) begin
      exp8.push_back(exp_t'{d: 9'(d), p: 1'b0, f: stop_low});
      if (d == 8'h00 && stop_low) brk8_exp++;
    end
    line8(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) line8(d[i], BIT_CLKS);
    line8(!stop_low, BIT_CLKS);
    line8(1'b1, BIT_CLKS * gap);
  endtask

  // Even parity: the parity error is set when data plus parity bit hold an odd number of ones.
  task automatic send7(input logic [6:0] d, input logic pbit, input logic stop_low, input int unsigned gap);
    exp7.push_back(exp_t'{d: 9'(d), p: 1'(($countones({d, pbit}) % 2) != 0), f: stop_low});
    if (d == 7'h00 && !pbit && stop_low) brk7_exp++;
    line7(1'b0, BIT_CLKS);
    for (int i = 0; i < 7; i++) line7(d[i], BIT_CLKS);
    line7(pbit, BIT_CLKS);
    line7(!stop_low, 2 * BIT_CLKS);
    line7(1'b1, BIT_CLKS * gap);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (exp8.size() == 0 && exp7.size() == 0) break;
      @(negedge clk);
    end
    chk({name, "_dut8_drained"}, 32'(exp8.size()), 32'd0);
    chk({name, "_dut7_drained"}, 32'(exp7.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int bbase;
    logic [7:0] d8;
    logic [6:0] d7;
    logic       p7;
    logic       sl;

    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid8", 32'(rx_valid8), 32'd0);
    chk("reset_data8", 32'(rx_data8), 32'd0);
    chk("reset_flags8", 32'({rx_perr8, rx_ferr8, rx_brk8, rx_ovr8}), 32'd0);
    chk("reset_valid7", 32'(rx_valid7), 32'd0);
    chk("reset_flags7", 32'({rx_perr7, rx_ferr7, rx_brk7, rx_ovr7}), 32'd0);
    align();

    // Two clean 8N1 frames, consumer always ready.
    line8(1'b1, 2 * BIT_CLKS);
    send8(8'h55, 1'b0, 2, 1'b1);
    chk("8n1_first_word", 32'(last8), 32'h55);
    chk("8n1_first_count", 32'(cnt8), 32'd1);
    send8(8'hA3, 1'b0, 2, 1'b1);
    chk("8n1_second_word", 32'(last8), 32'hA3);
    chk("8n1_second_count", 32'(cnt8), 32'd2);
    chk("8n1_second_ferr", 32'(last_ferr8), 32'd0);

    // 7E2 frames with correct and wrong parity.
    send7(7'h41, 1'b0, 1'b0, 2);
    chk("7e2_good_word", 32'(last7), 32'h41);
    chk("7e2_good_perr", 32'(last_perr7), 32'd0);
    send7(7'h41, 1'b1, 1'b0, 2);
    chk("7e2_bad_perr", 32'(last_perr7), 32'd1);
    chk("7e2_count", 32'(cnt7), 32'd2);

    // Short glitch must not produce a frame.
    base = cnt8;
    line8(1'b0, 4);
    line8(1'b1, 3 * BIT_CLKS);
    chk("glitch_no_frame", 32'(cnt8 - base), 32'd0);
    chk("glitch_valid_low", 32'(rx_valid8), 32'd0);

    // Long break: one all-zero frame with frame error, then nothing while held low.
    base  = cnt8;
    bbase = brk8_seen;
    exp8.push_back(exp_t'{d: 9'd0, p: 1'b0, f: 1'b1});
    brk8_exp++;
    line8(1'b0, 20 * BIT_CLKS);
    chk("break_frame_count", 32'(cnt8 - base), 32'd1);
    chk("break_pulse_count", 32'(brk8_seen - bbase), 32'd1);
    line8(1'b1, 3 * BIT_CLKS);
    chk("break_single_frame", 32'(cnt8 - base), 32'd1);
    chk("break_word", 32'(last8), 32'h00);
    chk("break_ferr", 32'(last_ferr8), 32'd1);

    // Overrun: consumer stalled across two frames, the second is lost.
    rforce8 = 1'b0;
    align();
    send8(8'h11, 1'b0, 2, 1'b1);
    send8(8'h22, 1'b0, 2, 1'b0);
    @(negedge clk);
    chk("overrun_valid", 32'(rx_valid8), 32'd1);
    chk("overrun_kept_word", 32'(rx_data8), 32'h11);
    chk("overrun_flag", 32'(rx_overrun_sample()), 32'd1);
    @(negedge clk);
    rforce8 = 1'b1;
    @(posedge clk);
    #3;
    rforce8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("overrun_valid_cleared", 32'(rx_valid8), 32'd0);
    chk("overrun_flag_cleared", 32'(rx_ovr8), 32'd0);
    rforce8 = 1'b1;
    align();

    // Reset in the middle of 0x7E abandons it; 0x33 follows.
    base = cnt8;
    line8(1'b0, BIT_CLKS);
    line8(1'b0, BIT_CLKS);
    line8(1'b1, BIT_CLKS);
    line8(1'b1, BIT_CLKS);
    line8(1'b1, BIT_CLKS);
    rxd8 = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    exp8.delete();
    exp7.delete();
    line8(1'b1, 2 * BIT_CLKS);
    chk("reset_abort_valid", 32'(rx_valid8), 32'd0);
    send8(8'h33, 1'b0, 2, 1'b1);
    chk("reset_abort_count", 32'(cnt8 - base), 32'd1);
    chk("reset_abort_word", 32'(last8), 32'h33);

    // Random 8N1 traffic with random backpressure and injected framing errors.
    rmode8 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d8 = 8'($urandom_range(0, 255));
      sl = ($urandom_range(0, 7) == 0);
      if (i % 10 == 3) begin
        d8 = 8'h00;
        sl = 1'b1;
      end
      send8(d8, sl, $urandom_range(1, 3), 1'b1);
    end
    rmode8 = 1'b0;
    drain("random8");

    // Random 7E2 traffic with random parity bits and framing errors.
    rmode7 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d7 = 7'($urandom_range(0, 127));
      p7 = 1'($urandom_range(0, 1));
      sl = ($urandom_range(0, 7) == 0);
      if (i % 8 == 5) begin
        d7 = 7'h00;
        p7 = 1'b0;
        sl = 1'b1;
      end
      send7(d7, p7, sl, $urandom_range(1, 3));
    end
    rmode7 = 1'b0;
    drain("random7");

    chk("break_total8", 32'(brk8_seen), 32'(brk8_exp));
    chk("break_total7", 32'(brk7_seen), 32'(brk7_exp));
    chk("final_overrun8", 32'(rx_ovr8), 32'd0);
    chk("final_overrun7", 32'(rx_ovr7), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic rx_overrun_sample();
    return rx_ovr8;
  endfunction

endmodule
